// File: rtl/control_sequencer_if.sv
// Control interface between the hardwired Mini SRC sequencer and the
// single-bus datapath: instruction/flag inputs plus every strobe it drives.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        ConFF_Out;
    logic        Stop;
    logic        Run;
    logic [4:0]  CONTROL;
    logic        PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out, InPort_Out;
    logic        PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In;
    logic        OutPort_In, ConFF_In;
    logic        IncPC, Read, Write;
    logic        G_RA, G_RB, G_RC, R_In, R_Out, BA_Out;

    // Sequencer side: reads IR and the branch flag, drives all control lines.
    modport master (
        input  IR, ConFF_Out, Stop,
        output Run, CONTROL,
        output PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out, InPort_Out,
        output PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In,
        output OutPort_In, ConFF_In, IncPC, Read, Write,
        output G_RA, G_RB, G_RC, R_In, R_Out, BA_Out
    );

    // Datapath side: supplies IR and the branch flag, consumes the strobes.
    modport slave (
        output IR, ConFF_Out, Stop,
        input  Run, CONTROL,
        input  PC_Out, MDR_Out, ZHI_Out, ZLO_Out, HI_Out, LO_Out, C_Out, InPort_Out,
        input  PC_In, MDR_In, MAR_In, IR_In, Y_In, ZHI_In, ZLO_In, HI_In, LO_In,
        input  OutPort_In, ConFF_In, IncPC, Read, Write,
        input  G_RA, G_RB, G_RC, R_In, R_Out, BA_Out
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: four fetch T-steps followed by up to six
// opcode-dependent execute T-steps, outputs decoded from state and opcode.
module control_sequencer #(
    parameter logic [4:0] ADD_CODE = 5'b00011,
    parameter logic [4:0] AND_CODE = 5'b00101,
    parameter logic [4:0] OR_CODE  = 5'b00110
) (
    input  logic Clock,
    input  logic Clear,
    control_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_F0, S_F1, S_F2, S_F3, S_E3, S_E4, S_E5, S_E6, S_E7, S_E8, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111, OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001, OP_NOT  = 5'b10010, OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100, OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_HALT = 5'b11011;

    state_t     state, next_state;
    logic [4:0] op;
    logic [2:0] n_exec;
    logic [3:0] e_num;
    logic       unused_ir;

    // Number of execute T-steps (E3 onward) for each opcode; 0 returns to F0 after F3.
    function automatic logic [2:0] exec_steps(input logic [4:0] o);
        case (o) inside
            OP_LD:                  return 3'd6;
            OP_ST:                  return 3'd5;
            OP_LDI:                 return 3'd3;
            [OP_ADD:OP_ORI]:        return 3'd3;
            OP_MUL, OP_DIV, OP_BR:  return 3'd4;
            OP_NEG, OP_NOT, OP_JAL: return 3'd2;
            [OP_JR:OP_MFLO]:        return 3'd1;
            default:                return 3'd0;
        endcase
    endfunction

    assign op        = bus.IR[31:27];
    assign n_exec    = exec_steps(op);
    assign e_num     = 4'(state) - 4'd3;   // E3 -> 1, E4 -> 2, ...
    // Register fields below the opcode are decoded by the datapath's select logic.
    assign unused_ir = ^bus.IR[26:0];

    // State register; Clear forces F0 so the first edge after release sees F0.
    always_ff @(posedge Clock) begin
        if (Clear) state <= S_F0;
        else       state <= next_state;
    end

    // Next-state: fetch chain, opcode-length execute chain, sticky HALT.
    always_comb begin
        next_state = state;
        case (state)
            S_F0:    next_state = bus.Stop ? S_HALT : S_F1;
            S_F1:    next_state = S_F2;
            S_F2:    next_state = S_F3;
            S_F3: begin
                if (op == OP_HALT)      next_state = S_HALT;
                else if (n_exec == 3'd0) next_state = S_F0;
                else                     next_state = S_E3;
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = ({1'b0, n_exec} <= e_num) ? S_F0 : state_t'(4'(state) + 4'd1);
        endcase
    end

    // Output decode: every line defaults low and is forced low while Clear is high.
    always_comb begin
        bus.Run = 1'b0;      bus.CONTROL = 5'b00000;
        bus.PC_Out = 1'b0;   bus.MDR_Out = 1'b0;  bus.ZHI_Out = 1'b0;    bus.ZLO_Out = 1'b0;
        bus.HI_Out = 1'b0;   bus.LO_Out = 1'b0;   bus.C_Out = 1'b0;      bus.InPort_Out = 1'b0;
        bus.PC_In = 1'b0;    bus.MDR_In = 1'b0;   bus.MAR_In = 1'b0;     bus.IR_In = 1'b0;
        bus.Y_In = 1'b0;     bus.ZHI_In = 1'b0;   bus.ZLO_In = 1'b0;     bus.HI_In = 1'b0;
        bus.LO_In = 1'b0;    bus.OutPort_In = 1'b0; bus.ConFF_In = 1'b0;
        bus.IncPC = 1'b0;    bus.Read = 1'b0;     bus.Write = 1'b0;
        bus.G_RA = 1'b0;     bus.G_RB = 1'b0;     bus.G_RC = 1'b0;
        bus.R_In = 1'b0;     bus.R_Out = 1'b0;    bus.BA_Out = 1'b0;
        if (!Clear) begin
            bus.Run = (state != S_HALT);
            case (state)
                S_F0: if (!bus.Stop) begin bus.PC_Out = 1'b1; bus.MAR_In = 1'b1; bus.IncPC = 1'b1; end
                S_F1: bus.Read = 1'b1;
                S_F2: begin bus.Read = 1'b1; bus.MDR_In = 1'b1; end
                S_F3: begin bus.MDR_Out = 1'b1; bus.IR_In = 1'b1; end
                S_HALT: ;
                default: begin
                    case (op) inside
                        [OP_ADD:OP_ORI]: case (state)
                            S_E3: begin bus.G_RB = 1'b1; bus.R_Out = 1'b1; bus.Y_In = 1'b1; end
                            S_E4: begin
                                bus.ZLO_In = 1'b1;
                                if (op <= OP_ROL) begin
                                    bus.G_RC = 1'b1; bus.R_Out = 1'b1; bus.CONTROL = op;
                                end else begin
                                    bus.C_Out = 1'b1;
                                    bus.CONTROL = (op == OP_ADDI) ? ADD_CODE :
                                                  (op == OP_ANDI) ? AND_CODE : OR_CODE;
                                end
                            end
                            S_E5: begin bus.ZLO_Out = 1'b1; bus.G_RA = 1'b1; bus.R_In = 1'b1; end
                            default: ;
                        endcase
                        OP_MUL, OP_DIV: case (state)
                            S_E3: begin bus.G_RA = 1'b1; bus.R_Out = 1'b1; bus.Y_In = 1'b1; end
                            S_E4: begin
                                bus.G_RB = 1'b1; bus.R_Out = 1'b1;
                                bus.ZHI_In = 1'b1; bus.ZLO_In = 1'b1; bus.CONTROL = op;
                            end
                            S_E5: begin bus.ZLO_Out = 1'b1; bus.LO_In = 1'b1; end
                            S_E6: begin bus.ZHI_Out = 1'b1; bus.HI_In = 1'b1; end
                            default: ;
                        endcase
                        OP_NEG, OP_NOT: case (state)
                            S_E3: begin bus.G_RB = 1'b1; bus.R_Out = 1'b1; bus.ZLO_In = 1'b1; bus.CONTROL = op; end
                            S_E4: begin bus.ZLO_Out = 1'b1; bus.G_RA = 1'b1; bus.R_In = 1'b1; end
                            default: ;
                        endcase
                        OP_LD, OP_LDI, OP_ST: case (state)
                            S_E3: begin bus.G_RB = 1'b1; bus.R_Out = 1'b1; bus.BA_Out = 1'b1; bus.Y_In = 1'b1; end
                            S_E4: begin bus.C_Out = 1'b1; bus.ZLO_In = 1'b1; bus.CONTROL = ADD_CODE; end
                            S_E5: begin
                                bus.ZLO_Out = 1'b1;
                                if (op == OP_LDI) begin bus.G_RA = 1'b1; bus.R_In = 1'b1; end
                                else              bus.MAR_In = 1'b1;
                            end
                            S_E6: begin
                                if (op == OP_LD) bus.Read = 1'b1;
                                else begin bus.G_RA = 1'b1; bus.R_Out = 1'b1; bus.MDR_In = 1'b1; end
                            end
                            S_E7: begin
                                if (op == OP_LD) begin bus.Read = 1'b1; bus.MDR_In = 1'b1; end
                                else             bus.Write = 1'b1;
                            end
                            S_E8: begin bus.MDR_Out = 1'b1; bus.G_RA = 1'b1; bus.R_In = 1'b1; end
                            default: ;
                        endcase
                        OP_BR: case (state)
                            S_E3: begin bus.G_RA = 1'b1; bus.R_Out = 1'b1; bus.ConFF_In = 1'b1; end
                            S_E4: begin bus.PC_Out = 1'b1; bus.Y_In = 1'b1; end
                            S_E5: begin bus.C_Out = 1'b1; bus.ZLO_In = 1'b1; bus.CONTROL = ADD_CODE; end
                            S_E6: begin bus.ZLO_Out = 1'b1; bus.PC_In = bus.ConFF_Out; end
                            default: ;
                        endcase
                        OP_JR: begin bus.G_RA = 1'b1; bus.R_Out = 1'b1; bus.PC_In = 1'b1; end
                        OP_JAL: case (state)
                            S_E3: begin bus.PC_Out = 1'b1; bus.G_RB = 1'b1; bus.R_In = 1'b1; end
                            S_E4: begin bus.G_RA = 1'b1; bus.R_Out = 1'b1; bus.PC_In = 1'b1; end
                            default: ;
                        endcase
                        OP_IN:   begin bus.InPort_Out = 1'b1; bus.G_RA = 1'b1; bus.R_In = 1'b1; end
                        OP_OUT:  begin bus.G_RA = 1'b1; bus.R_Out = 1'b1; bus.OutPort_In = 1'b1; end
                        OP_MFHI: begin bus.HI_Out = 1'b1; bus.G_RA = 1'b1; bus.R_In = 1'b1; end
                        OP_MFLO: begin bus.LO_Out = 1'b1; bus.G_RA = 1'b1; bus.R_In = 1'b1; end
                        default: ;
                    endcase
                end
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle stimulus and expected control word
// are queued per scenario, then replayed one clock at a time.
module tb_control_sequencer;
    logic Clock = 1'b0;
    logic Clear;

    control_sequencer_if bus();
    control_sequencer dut (.Clock(Clock), .Clear(Clear), .bus(bus));

    always #5 Clock = ~Clock;

    typedef logic [33:0] vec_t;
    localparam vec_t PC_O   = 34'd1 << 0,  MDR_O  = 34'd1 << 1,  ZHI_O  = 34'd1 << 2;
    localparam vec_t ZLO_O  = 34'd1 << 3,  HI_O   = 34'd1 << 4,  LO_O   = 34'd1 << 5;
    localparam vec_t C_O    = 34'd1 << 6,  INP_O  = 34'd1 << 7,  PC_I   = 34'd1 << 8;
    localparam vec_t MDR_I  = 34'd1 << 9,  MAR_I  = 34'd1 << 10, IR_I   = 34'd1 << 11;
    localparam vec_t Y_I    = 34'd1 << 12, ZHI_I  = 34'd1 << 13, ZLO_I  = 34'd1 << 14;
    localparam vec_t HI_I   = 34'd1 << 15, LO_I   = 34'd1 << 16, OUTP_I = 34'd1 << 17;
    localparam vec_t CONF_I = 34'd1 << 18, INCPC  = 34'd1 << 19, READ   = 34'd1 << 20;
    localparam vec_t WRITE  = 34'd1 << 21, G_RA   = 34'd1 << 22, G_RB   = 34'd1 << 23;
    localparam vec_t G_RC   = 34'd1 << 24, R_IN   = 34'd1 << 25, R_OUT  = 34'd1 << 26;
    localparam vec_t BA_O   = 34'd1 << 27, RUN    = 34'd1 << 33;
    localparam vec_t F0_V   = RUN | PC_O | MAR_I | INCPC;

    typedef struct packed {
        logic        clr;
        logic        stop;
        logic        conff;
        logic [31:0] ir;
        vec_t        want;
    } step_t;

    step_t       sb[$];
    logic        cur_clr, cur_stop, cur_conff;
    logic [31:0] cur_ir;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic vec_t ctl(input logic [4:0] c);
        return vec_t'(c) << 28;
    endfunction

    function automatic vec_t sample();
        return {bus.Run, bus.CONTROL, bus.BA_Out, bus.R_Out, bus.R_In, bus.G_RC, bus.G_RB,
                bus.G_RA, bus.Write, bus.Read, bus.IncPC, bus.ConFF_In, bus.OutPort_In,
                bus.LO_In, bus.HI_In, bus.ZLO_In, bus.ZHI_In, bus.Y_In, bus.IR_In, bus.MAR_In,
                bus.MDR_In, bus.PC_In, bus.InPort_Out, bus.C_Out, bus.LO_Out, bus.HI_Out,
                bus.ZLO_Out, bus.ZHI_Out, bus.MDR_Out, bus.PC_Out};
    endfunction

    task automatic push(input vec_t w);
        sb.push_back('{cur_clr, cur_stop, cur_conff, cur_ir, w});
    endtask

    task automatic push_fetch(input logic [31:0] ir);
        cur_ir = ir;
        push(F0_V); push(RUN | READ); push(RUN | READ | MDR_I); push(RUN | MDR_O | IR_I);
    endtask

    task automatic test_reset();
        step_t s; vec_t got;
        cur_clr = 1'b1; cur_stop = 1'b0; cur_conff = 1'b0; cur_ir = 32'h18910000;
        push('0); push('0);
        cur_clr = 1'b0; push(F0_V);
        cur_clr = 1'b1; push('0);          // abort during F1
        cur_clr = 1'b0;
        for (int i = 0; sb.size() > 0; i++) begin
            s = sb.pop_front();
            Clear = s.clr; bus.Stop = s.stop; bus.ConFF_Out = s.conff; bus.IR = s.ir;
            @(negedge Clock); got = sample(); n_checks++;
            if (got !== s.want) begin
                n_fail++; $display("FAIL reset cycle %0d: got %h required %h", i, got, s.want);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_add();
        step_t s; vec_t got;
        push_fetch(32'h18910000);
        push(RUN | G_RB | R_OUT | Y_I);
        push(RUN | G_RC | R_OUT | ZLO_I | ctl(5'b00011));
        push(RUN | ZLO_O | G_RA | R_IN);
        push_fetch(32'hD0000000);          // nop: its F0 lands exactly 7 cycles after add's
        for (int i = 0; sb.size() > 0; i++) begin
            s = sb.pop_front();
            Clear = s.clr; bus.Stop = s.stop; bus.ConFF_Out = s.conff; bus.IR = s.ir;
            @(negedge Clock); got = sample(); n_checks++;
            if (got !== s.want) begin
                n_fail++; $display("FAIL add cycle %0d: got %h required %h", i, got, s.want);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_ld();
        step_t s; vec_t got;
        push_fetch(32'h00800005);
        push(RUN | G_RB | R_OUT | BA_O | Y_I);
        push(RUN | C_O | ZLO_I | ctl(5'b00011));
        push(RUN | ZLO_O | MAR_I);
        push(RUN | READ);
        push(RUN | READ | MDR_I);
        push(RUN | MDR_O | G_RA | R_IN);
        push_fetch(32'hD0000000);
        for (int i = 0; sb.size() > 0; i++) begin
            s = sb.pop_front();
            Clear = s.clr; bus.Stop = s.stop; bus.ConFF_Out = s.conff; bus.IR = s.ir;
            @(negedge Clock); got = sample(); n_checks++;
            if (got !== s.want) begin
                n_fail++; $display("FAIL ld cycle %0d: got %h required %h", i, got, s.want);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_br();
        step_t s; vec_t got;
        for (int c = 0; c < 2; c++) begin
            cur_conff = (c == 1);
            push_fetch(32'h98000000);
            push(RUN | G_RA | R_OUT | CONF_I);
            push(RUN | PC_O | Y_I);
            push(RUN | C_O | ZLO_I | ctl(5'b00011));
            push(RUN | ZLO_O | ((c == 1) ? PC_I : vec_t'(0)));
        end
        cur_conff = 1'b0;
        for (int i = 0; sb.size() > 0; i++) begin
            s = sb.pop_front();
            Clear = s.clr; bus.Stop = s.stop; bus.ConFF_Out = s.conff; bus.IR = s.ir;
            @(negedge Clock); got = sample(); n_checks++;
            if (got !== s.want) begin
                n_fail++; $display("FAIL br cycle %0d: got %h required %h", i, got, s.want);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_mul();
        step_t s; vec_t got;
        push_fetch(32'h78000000);
        push(RUN | G_RA | R_OUT | Y_I);
        push(RUN | G_RB | R_OUT | ZHI_I | ZLO_I | ctl(5'b01111));
        push(RUN | ZLO_O | LO_I);
        push(RUN | ZHI_O | HI_I);
        for (int i = 0; sb.size() > 0; i++) begin
            s = sb.pop_front();
            Clear = s.clr; bus.Stop = s.stop; bus.ConFF_Out = s.conff; bus.IR = s.ir;
            @(negedge Clock); got = sample(); n_checks++;
            if (got !== s.want) begin
                n_fail++; $display("FAIL mul cycle %0d: got %h required %h", i, got, s.want);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_misc();
        step_t s; vec_t got;
        push_fetch(32'h68000000);          // andi
        push(RUN | G_RB | R_OUT | Y_I); push(RUN | C_O | ZLO_I | ctl(5'b00101));
        push(RUN | ZLO_O | G_RA | R_IN);
        push_fetch(32'h10000000);          // st
        push(RUN | G_RB | R_OUT | BA_O | Y_I); push(RUN | C_O | ZLO_I | ctl(5'b00011));
        push(RUN | ZLO_O | MAR_I); push(RUN | G_RA | R_OUT | MDR_I); push(RUN | WRITE);
        push_fetch(32'h90000000);          // not
        push(RUN | G_RB | R_OUT | ZLO_I | ctl(5'b10010)); push(RUN | ZLO_O | G_RA | R_IN);
        push_fetch(32'hA0000000);          // jr
        push(RUN | G_RA | R_OUT | PC_I);
        push_fetch(32'hA8000000);          // jal
        push(RUN | PC_O | G_RB | R_IN); push(RUN | G_RA | R_OUT | PC_I);
        push_fetch(32'hB0000000); push(RUN | INP_O | G_RA | R_IN);    // in
        push_fetch(32'hB8000000); push(RUN | G_RA | R_OUT | OUTP_I);  // out
        push_fetch(32'hC0000000); push(RUN | HI_O | G_RA | R_IN);     // mfhi
        push_fetch(32'hC8000000); push(RUN | LO_O | G_RA | R_IN);     // mflo
        push_fetch(32'hD0000000);          // nop
        push_fetch(32'hF0000000);          // undefined opcode
        for (int i = 0; sb.size() > 0; i++) begin
            s = sb.pop_front();
            Clear = s.clr; bus.Stop = s.stop; bus.ConFF_Out = s.conff; bus.IR = s.ir;
            @(negedge Clock); got = sample(); n_checks++;
            if (got !== s.want) begin
                n_fail++; $display("FAIL misc cycle %0d: got %h required %h", i, got, s.want);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_stop_mid_add();
        step_t s; vec_t got;
        cur_ir = 32'h18910000;
        push(F0_V); push(RUN | READ);
        cur_stop = 1'b1;                   // raised mid-instruction: add must finish
        push(RUN | READ | MDR_I); push(RUN | MDR_O | IR_I);
        push(RUN | G_RB | R_OUT | Y_I);
        push(RUN | G_RC | R_OUT | ZLO_I | ctl(5'b00011));
        push(RUN | ZLO_O | G_RA | R_IN);
        push(RUN);                         // F0 with Stop: no strobes
        push('0);                          // HALT
        cur_stop = 1'b0;
        push('0); push('0); push('0);
        for (int i = 0; sb.size() > 0; i++) begin
            s = sb.pop_front();
            Clear = s.clr; bus.Stop = s.stop; bus.ConFF_Out = s.conff; bus.IR = s.ir;
            @(negedge Clock); got = sample(); n_checks++;
            if (got !== s.want) begin
                n_fail++; $display("FAIL stop cycle %0d: got %h required %h", i, got, s.want);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_halt();
        step_t s; vec_t got;
        cur_clr = 1'b1; push('0);
        cur_clr = 1'b0;
        push_fetch(32'hD8000000);
        for (int k = 0; k < 20; k++) begin
            cur_stop = k[0];
            push('0);
        end
        cur_stop = 1'b0;
        cur_clr = 1'b1; push('0);
        cur_clr = 1'b0; push(F0_V);
        for (int i = 0; sb.size() > 0; i++) begin
            s = sb.pop_front();
            Clear = s.clr; bus.Stop = s.stop; bus.ConFF_Out = s.conff; bus.IR = s.ir;
            @(negedge Clock); got = sample(); n_checks++;
            if (got !== s.want) begin
                n_fail++; $display("FAIL halt cycle %0d: got %h required %h", i, got, s.want);
            end
            @(posedge Clock); #1;
        end
    endtask

    initial begin
        Clear = 1'b1; bus.Stop = 1'b0; bus.ConFF_Out = 1'b0; bus.IR = 32'h0;
        @(posedge Clock); #1;
        test_reset();
        test_add();
        test_ld();
        test_br();
        test_mul();
        test_misc();
        test_stop_mid_add();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
